// File: rtl/alarm_pkg.sv
// Shared constants for the alarm sequencing stage: state encoding, BCD digit widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;

    localparam int HR_TENS_W   = 2;
    localparam int HR_UNITS_W  = 4;
    localparam int MIN_TENS_W  = 3;
    localparam int MIN_UNITS_W = 4;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Bundle of time/alarm digits, controls and status outputs of the alarm stage.
// Latency: n/a (wires only).
// Backpressure: none; ticks and buttons are single-cycle pulses.
interface alarm_controller_if;
    import alarm_pkg::*;

    logic                   sec_tick;
    logic [HR_TENS_W-1:0]   cur_hr_tens;
    logic [HR_UNITS_W-1:0]  cur_hr_units;
    logic [MIN_TENS_W-1:0]  cur_min_tens;
    logic [MIN_UNITS_W-1:0] cur_min_units;
    logic [HR_TENS_W-1:0]   alm_hr_tens;
    logic [HR_UNITS_W-1:0]  alm_hr_units;
    logic [MIN_TENS_W-1:0]  alm_min_tens;
    logic [MIN_UNITS_W-1:0] alm_min_units;
    logic                   alarm_en;
    logic                   snooze_btn;
    logic                   stop_btn;
    logic                   buzzer;
    logic                   ringing;
    logic                   snoozed;
    logic [1:0]             state;

    modport master (
        output sec_tick, cur_hr_tens, cur_hr_units, cur_min_tens, cur_min_units,
               alm_hr_tens, alm_hr_units, alm_min_tens, alm_min_units,
               alarm_en, snooze_btn, stop_btn,
        input  buzzer, ringing, snoozed, state
    );

    modport slave (
        input  sec_tick, cur_hr_tens, cur_hr_units, cur_min_tens, cur_min_units,
               alm_hr_tens, alm_hr_units, alm_min_tens, alm_min_units,
               alarm_en, snooze_btn, stop_btn,
        output buzzer, ringing, snoozed, state
    );

endinterface

// File: rtl/alarm_match.sv
// Compares current time to alarm setting and emits a one-cycle trigger on the match rising edge.
// Latency: trigger is combinational from the digits; match_q lags match by one cycle.
// Backpressure: none.
module alarm_match
    import alarm_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alarm_en_i,
    input  logic [HR_TENS_W-1:0]   cur_hr_tens_i,
    input  logic [HR_UNITS_W-1:0]  cur_hr_units_i,
    input  logic [MIN_TENS_W-1:0]  cur_min_tens_i,
    input  logic [MIN_UNITS_W-1:0] cur_min_units_i,
    input  logic [HR_TENS_W-1:0]   alm_hr_tens_i,
    input  logic [HR_UNITS_W-1:0]  alm_hr_units_i,
    input  logic [MIN_TENS_W-1:0]  alm_min_tens_i,
    input  logic [MIN_UNITS_W-1:0] alm_min_units_i,
    output logic                   trigger_o
);

    logic match;
    logic match_q;

    assign match = alarm_en_i
                 && (cur_hr_tens_i   == alm_hr_tens_i)
                 && (cur_hr_units_i  == alm_hr_units_i)
                 && (cur_min_tens_i  == alm_min_tens_i)
                 && (cur_min_units_i == alm_min_units_i);

    // Previous-cycle match; resets high so a time already matching at reset release does not ring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_q <= 1'b1;
        else       match_q <= match;
    end

    assign trigger_o = match & ~match_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm ring/snooze sequencer driving buzzer and status, timed in 1 Hz sec_tick enables.
// Latency: trigger or button in cycle N is visible on registered outputs in cycle N+1.
// Backpressure: none; a button coincident with sec_tick wins and the tick is dropped.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);

    localparam int RING_W = cnt_w(RING_SECONDS);
    localparam int SNZ_W  = cnt_w(SNOOZE_SECONDS);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SECONDS - 1);

    logic              trigger;
    logic [1:0]        state_q,    state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q,  snz_cnt_d;
    logic              buzzer_q,   buzzer_d;

    alarm_match u_match (
        .clk             (clk),
        .reset           (reset),
        .alarm_en_i      (bus.alarm_en),
        .cur_hr_tens_i   (bus.cur_hr_tens),
        .cur_hr_units_i  (bus.cur_hr_units),
        .cur_min_tens_i  (bus.cur_min_tens),
        .cur_min_units_i (bus.cur_min_units),
        .alm_hr_tens_i   (bus.alm_hr_tens),
        .alm_hr_units_i  (bus.alm_hr_units),
        .alm_min_tens_i  (bus.alm_min_tens),
        .alm_min_units_i (bus.alm_min_units),
        .trigger_o       (trigger)
    );

    // Next-state, counters and buzzer; stop/disable beats snooze, which beats the tick.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        buzzer_d   = buzzer_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    buzzer_d   = 1'b1;
                end
            end
            RINGING: begin
                if (bus.stop_btn || !bus.alarm_en) begin
                    state_d = IDLE;
                end else if (bus.snooze_btn) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = '0;
                end else if (bus.sec_tick) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RING_W'(1);
                        buzzer_d   = ~buzzer_q;
                    end
                end
            end
            SNOOZE: begin
                if (bus.stop_btn || !bus.alarm_en) begin
                    state_d = IDLE;
                end else if (bus.sec_tick) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q + SNZ_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != RINGING) buzzer_d = 1'b0;
    end

    // State, counters and buzzer registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.ringing = (state_q == RINGING);
    assign bus.snoozed = (state_q == SNOOZE);
    assign bus.buzzer  = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with RING_SECONDS=3, SNOOZE_SECONDS=2.
// Outputs are sampled 1 ns after the rising edge; inputs change at that same point.
// Expected values are hand-derived from the ring/snooze rules.
module tb_alarm_controller;
    import alarm_pkg::*;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    alarm_controller_if bus ();

    alarm_controller #(
        .RING_SECONDS   (3),
        .SNOOZE_SECONDS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        total++;
        assert (obs === req) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.sec_tick = 1'b1;
        step();
        bus.sec_tick = 1'b0;
    endtask

    task automatic set_time(input int ht, input int hu, input int mt, input int mu);
        bus.cur_hr_tens   = HR_TENS_W'(ht);
        bus.cur_hr_units  = HR_UNITS_W'(hu);
        bus.cur_min_tens  = MIN_TENS_W'(mt);
        bus.cur_min_units = MIN_UNITS_W'(mu);
    endtask

    task automatic set_alarm(input int ht, input int hu, input int mt, input int mu);
        bus.alm_hr_tens   = HR_TENS_W'(ht);
        bus.alm_hr_units  = HR_UNITS_W'(hu);
        bus.alm_min_tens  = MIN_TENS_W'(mt);
        bus.alm_min_units = MIN_UNITS_W'(mu);
    endtask

    // Move time off 07:30 and back so the comparator sees a fresh rising edge.
    task automatic retrigger();
        set_time(0, 7, 3, 1);
        step();
        set_time(0, 7, 3, 0);
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        bus.sec_tick   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.alarm_en   = 1'b1;
        set_alarm(0, 7, 3, 0);
        set_time(0, 7, 2, 9);
        #1;
        check("rst_state",   bus.state,   8'd0);
        check("rst_buzzer",  bus.buzzer,  8'd0);
        check("rst_ringing", bus.ringing, 8'd0);
        check("rst_snoozed", bus.snoozed, 8'd0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check("idle_0729", bus.ringing, 8'd0);

        // 07:29 -> 07:30 rings one cycle later, toggles on two ticks, ends on the third.
        set_time(0, 7, 3, 0);
        step();
        check("trig_ringing", bus.ringing, 8'd1);
        check("trig_buzzer",  bus.buzzer,  8'd1);
        check("trig_state",   bus.state,   8'd1);
        step();
        check("no_tick_hold", bus.buzzer, 8'd1);
        tick();
        check("tick1_buzzer",  bus.buzzer,  8'd0);
        check("tick1_ringing", bus.ringing, 8'd1);
        tick();
        check("tick2_buzzer", bus.buzzer, 8'd1);
        tick();
        check("tick3_state",  bus.state,  8'd0);
        check("tick3_buzzer", bus.buzzer, 8'd0);

        // Snooze, ignored second snooze, re-ring after two ticks with ring_cnt restarted.
        retrigger();
        check("s2_ringing", bus.ringing, 8'd1);
        bus.snooze_btn = 1'b1;
        step();
        bus.snooze_btn = 1'b0;
        check("snz_snoozed", bus.snoozed, 8'd1);
        check("snz_buzzer",  bus.buzzer,  8'd0);
        check("snz_state",   bus.state,   8'd2);
        tick();
        check("snz_tick1", bus.snoozed, 8'd1);
        bus.snooze_btn = 1'b1;
        step();
        bus.snooze_btn = 1'b0;
        check("snz_no_extend_btn", bus.state, 8'd2);
        tick();
        check("rering_state",  bus.state,  8'd1);
        check("rering_buzzer", bus.buzzer, 8'd1);
        tick();
        check("rering_t1_buzzer", bus.buzzer, 8'd0);
        tick();
        check("rering_t2_buzzer",  bus.buzzer,  8'd1);
        check("rering_t2_ringing", bus.ringing, 8'd1);
        tick();
        check("rering_t3_state", bus.state, 8'd0);

        // Stop + snooze + tick together: stop wins; no re-ring while time stays at 07:30.
        retrigger();
        check("s3_ringing", bus.ringing, 8'd1);
        bus.stop_btn   = 1'b1;
        bus.snooze_btn = 1'b1;
        bus.sec_tick   = 1'b1;
        step();
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.sec_tick   = 1'b0;
        check("stop_state",  bus.state,  8'd0);
        check("stop_buzzer", bus.buzzer, 8'd0);
        for (int i = 0; i < 60; i++) begin
            tick();
            check("no_rering", bus.ringing, 8'd0);
        end

        // Buttons in IDLE are ignored.
        bus.stop_btn   = 1'b1;
        bus.snooze_btn = 1'b1;
        step();
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        check("idle_btn_ignored", bus.state, 8'd0);

        // Dropping alarm_en during SNOOZE returns to IDLE with all outputs low.
        retrigger();
        bus.snooze_btn = 1'b1;
        step();
        bus.snooze_btn = 1'b0;
        check("s4_snoozed", bus.snoozed, 8'd1);
        bus.alarm_en = 1'b0;
        step();
        check("dis_state",   bus.state,   8'd0);
        check("dis_buzzer",  bus.buzzer,  8'd0);
        check("dis_ringing", bus.ringing, 8'd0);
        check("dis_snoozed", bus.snoozed, 8'd0);
        set_time(0, 7, 3, 1);
        step();
        bus.alarm_en = 1'b1;
        step();

        // Time matching through reset release does not ring; away-and-back does.
        set_time(0, 7, 3, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        check("match_thru_reset", bus.state, 8'd0);
        retrigger();
        check("after_reset_ring", bus.ringing, 8'd1);

        // Asynchronous reset between edges clears state and buzzer before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state",  bus.state,  8'd0);
        check("async_rst_buzzer", bus.buzzer, 8'd0);
        set_time(1, 2, 4, 5);
        step();
        reset = 1'b0;
        step();
        check("edit_pre_idle", bus.state, 8'd0);

        // Editing the alarm to equal the current time rings on the next cycle.
        set_alarm(1, 2, 4, 5);
        step();
        check("edit_ring",   bus.ringing, 8'd1);
        check("edit_buzzer", bus.buzzer,  8'd1);
        bus.stop_btn = 1'b1;
        step();
        bus.stop_btn = 1'b0;
        check("edit_stop", bus.state, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
